// File: rtl/image_capture_dma_pkg.sv
// Shared types and constants for the image capture DMA.
package image_capture_dma_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

    // Byte enables for a word whose last valid byte sits in lane 0..3.
    localparam logic [3:0] BE_LANE0 = 4'b0001;
    localparam logic [3:0] BE_LANE1 = 4'b0011;
    localparam logic [3:0] BE_LANE2 = 4'b0111;
    localparam logic [3:0] BE_LANE3 = 4'b1111;

    function automatic logic [3:0] be_upto_lane(input logic [1:0] lane);
        case (lane)
            2'd0:    return BE_LANE0;
            2'd1:    return BE_LANE1;
            2'd2:    return BE_LANE2;
            default: return BE_LANE3;
        endcase
    endfunction

endpackage

// File: rtl/image_capture_dma_if.sv
// Avalon-MM write-master bus between the capture DMA and memory.
interface image_capture_dma_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest
    );
endinterface

// File: rtl/image_capture_dma_wr_fifo.sv
// First-word-fall-through FIFO holding {byteenable, data} words for the bus.
module capture_wr_fifo
    import image_capture_dma_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_wr, do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; written only, never cleared.
    // NOTE: the data array has no reset -- occupancy comes from count, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/image_capture_dma.sv
// Packs an 8-bit pixel stream into 32-bit words and writes them to memory
// through an Avalon-MM master, starting at buff, for capture_imgsize bytes.
module image_capture_dma
    import image_capture_dma_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int ADDR_W     = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_capture,
    input  logic [23:0] capture_imgsize,
    input  logic [31:0] buff,
    output logic        image_captured,
    output logic        capture_standby,
    output logic        overflow,
    input  logic [7:0]  in_pix,
    input  logic        in_valid,
    input  logic        in_frame_valid,
    image_capture_dma_if.master avm
);
    state_t            state_q, state_d;
    logic              start_r1, start_r2, fv_q;
    logic              start_rise, fv_rise, fv_fall;
    logic [23:0]       remaining_q;
    logic [1:0]        lane_q;
    logic [31:0]       word_q, word_next;
    logic [ADDR_W-1:0] addr_q;
    logic              overflow_q;
    logic              start_go, pix_take, push_req;
    logic [3:0]        push_be;
    logic              fifo_full, fifo_empty, fifo_wr, bus_accept;
    logic [35:0]       fifo_rd_data;

    assign start_rise = start_r1 && !start_r2;
    assign fv_rise    = in_frame_valid && !fv_q;
    assign fv_fall    = !in_frame_valid && fv_q;

    // Edge-detection history for the start request and the frame strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_r1 <= 1'b0;
            start_r2 <= 1'b0;
            fv_q     <= 1'b0;
        end else begin
            start_r1 <= start_capture;
            start_r2 <= start_r1;
            fv_q     <= in_frame_valid;
        end
    end

    // State register.
    // NOTE: all clocked state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and per-cycle capture strobes.
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        pix_take = 1'b0;
        push_req = 1'b0;
        push_be  = BE_LANE3;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    start_go = 1'b1;
                    state_d  = (capture_imgsize == 24'd0) ? DONE : WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (fv_rise) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (fv_fall) begin
                    // Frame ended early: flush whatever is partially packed.
                    push_req = (lane_q != 2'd0);
                    push_be  = be_upto_lane(lane_q - 2'd1);
                    state_d  = DRAIN;
                end else if (in_valid) begin
                    pix_take = 1'b1;
                    if (lane_q == 2'd3 || remaining_q == 24'd1) begin
                        push_req = 1'b1;
                        push_be  = be_upto_lane(lane_q);
                    end
                    if (remaining_q == 24'd1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Insert the incoming pixel into its byte lane; a dropped pixel leaves the word untouched.
    always_comb begin
        word_next = word_q;
        if (pix_take && !fifo_full) word_next[{lane_q, 3'b000} +: 8] = in_pix;
    end

    // Capture datapath: byte counter, packing register, address and overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            lane_q      <= '0;
            word_q      <= '0;
            overflow_q  <= 1'b0;
        end else if (start_go) begin
            addr_q      <= ADDR_W'(buff & 32'hFFFF_FFFC);
            remaining_q <= capture_imgsize;
            lane_q      <= '0;
            word_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            // Dropped pixels still advance the count so the end point stays fixed.
            if (pix_take) begin
                remaining_q <= remaining_q - 24'd1;
                lane_q      <= lane_q + 2'd1;
            end
            if (push_req)      word_q <= '0;
            else if (pix_take) word_q <= word_next;
            if ((pix_take || push_req) && fifo_full) overflow_q <= 1'b1;
            if (bus_accept) addr_q <= addr_q + ADDR_W'(4);
        end
    end

    assign fifo_wr    = push_req && !fifo_full;
    assign bus_accept = !fifo_empty && !avm.avm_waitrequest;

    capture_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (36)
    ) u_wr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fifo_wr),
        .wr_data ({push_be, word_next}),
        .rd_en   (bus_accept),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign avm.avm_write      = !fifo_empty;
    assign avm.avm_address    = addr_q;
    assign avm.avm_writedata  = fifo_empty ? 32'd0 : fifo_rd_data[31:0];
    assign avm.avm_byteenable = fifo_empty ? 4'd0  : fifo_rd_data[35:32];

    assign image_captured  = (state_q == DONE);
    assign capture_standby = (state_q == IDLE);
    assign overflow        = overflow_q;
endmodule

// File: tb/tb_image_capture_dma.sv
// Self-checking bench for image_capture_dma: directed and randomized captures
// compared against a word-list model derived from the byte stream.
module tb_image_capture_dma;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic        start_capture;
    logic [23:0] capture_imgsize;
    logic [31:0] buff;
    logic        image_captured;
    logic        capture_standby;
    logic        overflow;
    logic [7:0]  in_pix;
    logic        in_valid;
    logic        in_frame_valid;
    logic        wr_wait;

    int   vectors = 0;
    int   miscompares = 0;
    int   done_count = 0;
    int   wait_mode = 0;
    int   wait_phase = 0;
    wr_t  got_q[$];
    logic [7:0] pix_q[$];
    logic stall_prev = 1'b0;
    wr_t  prev_w;

    image_capture_dma_if #(.ADDR_W(32)) avm_bus ();
    assign avm_bus.avm_waitrequest = wr_wait;

    image_capture_dma #(.FIFO_DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start_capture   (start_capture),
        .capture_imgsize (capture_imgsize),
        .buff            (buff),
        .image_captured  (image_captured),
        .capture_standby (capture_standby),
        .overflow        (overflow),
        .in_pix          (in_pix),
        .in_valid        (in_valid),
        .in_frame_valid  (in_frame_valid),
        .avm             (avm_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave model: waitrequest pattern selected by wait_mode.
    initial begin
        wr_wait = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wait_phase++;
            case (wait_mode)
                0:       wr_wait = 1'b0;
                1:       wr_wait = ((wait_phase % 4) != 3);
                2:       wr_wait = 1'b1;
                default: wr_wait = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Bus monitor: records accepted writes, checks stall stability, counts done pulses.
    always @(negedge clk) begin
        wr_t cur;
        cur = '{addr: avm_bus.avm_address, data: avm_bus.avm_writedata, be: avm_bus.avm_byteenable};
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("hold_while_stalled", cur, prev_w);
            if (avm_bus.avm_write && !avm_bus.avm_waitrequest) got_q.push_back(cur);
            stall_prev = avm_bus.avm_write && avm_bus.avm_waitrequest;
            prev_w = cur;
            if (image_captured) done_count++;
        end
    end

    // Reference: the first min(delivered, size) bytes, four per word, lane order, consecutive addresses.
    function automatic void build_expected(input logic [31:0] base, input int size, input int npix,
                                           input int max_words, output wr_t exp_q[$]);
        int n, nw;
        exp_q.delete();
        n  = (npix < size) ? npix : size;
        nw = (n + 3) / 4;
        if (nw > max_words) nw = max_words;
        for (int w = 0; w < nw; w++) begin
            wr_t e;
            e.addr = (base & 32'hFFFF_FFFC) + 32'(4 * w);
            e.data = '0;
            e.be   = '0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < n) begin
                    e.data[8*b +: 8] = pix_q[4*w + b];
                    e.be[b] = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
    endfunction

    task automatic fill_seq(input logic [7:0] first, input int n);
        pix_q.delete();
        for (int i = 0; i < n; i++) pix_q.push_back(first + 8'(i));
    endtask

    task automatic fill_rand(input int n);
        pix_q.delete();
        for (int i = 0; i < n; i++) pix_q.push_back(8'($urandom));
    endtask

    // One full capture: start, frame of pix_q[0..npix-1], wait for done, compare writes.
    task automatic run_capture(input string tag, input logic [31:0] base, input int size, input int npix,
                               input bit gaps, input int mode, input bit stall_all);
        wr_t exp_q[$];
        wr_t g;
        int  d0, n;
        got_q.delete();
        d0 = done_count;
        wait_mode = stall_all ? 2 : mode;
        buff = base;
        capture_imgsize = 24'(size);
        start_capture = 1'b1;
        tick();
        tick();
        start_capture = 1'b0;
        in_frame_valid = 1'b1;
        tick();
        for (int i = 0; i < npix; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            in_pix = pix_q[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        tick();
        in_frame_valid = 1'b0;
        if (stall_all) begin
            repeat (5) tick();
            check({tag, "_overflow_set"}, overflow, 1'b1);
            check({tag, "_no_write_while_stalled"}, got_q.size(), 0);
            wait_mode = 0;
        end
        n = 0;
        while (done_count == d0 && n < 3000) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check({tag, "_done_pulses"}, done_count - d0, 1);
        check({tag, "_standby"}, capture_standby, 1'b1);
        if (!stall_all) check({tag, "_no_overflow"}, overflow, 1'b0);
        build_expected(base, size, npix, stall_all ? DEPTH : 1 << 22, exp_q);
        check({tag, "_write_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            check($sformatf("%s_write%0d", tag, i), g, exp_q[i]);
        end
    endtask

    initial begin
        wr_t w;
        int  d0, sz, np;
        logic [31:0] base;
        reset_n = 1'b0;
        start_capture = 1'b0;
        capture_imgsize = '0;
        buff = '0;
        in_pix = '0;
        in_valid = 1'b0;
        in_frame_valid = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_image_captured", image_captured, 1'b0);
        check("rst_standby", capture_standby, 1'b1);
        check("rst_overflow", overflow, 1'b0);
        check("rst_avm_write", avm_bus.avm_write, 1'b0);
        check("rst_avm_address", avm_bus.avm_address, 32'd0);
        check("rst_avm_writedata", avm_bus.avm_writedata, 32'd0);
        check("rst_avm_byteenable", avm_bus.avm_byteenable, 4'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Basic 8-byte capture
        fill_seq(8'h01, 8);
        run_capture("basic", 32'h1000_0000, 8, 8, 1'b0, 0, 1'b0);
        w = (got_q.size() > 0) ? got_q[0] : '0;
        check("basic_word0", w, {32'h1000_0000, 32'h0403_0201, 4'hF});

        // Partial last word
        fill_seq(8'hA0, 6);
        run_capture("partial", 32'h2000_0000, 6, 6, 1'b0, 0, 1'b0);
        w = (got_q.size() > 1) ? got_q[1] : '0;
        check("partial_lo16", w.data[15:0], 16'hA5A4);
        check("partial_be", w.be, 4'b0011);

        // Backpressure: 3 cycles stalled, 1 free
        fill_rand(32);
        run_capture("backpressure", 32'h3000_0040, 32, 32, 1'b0, 1, 1'b0);

        // Overflow: bus stalled for the whole 64-byte frame
        fill_seq(8'h01, 64);
        run_capture("overflow", 32'h4000_0000, 64, 64, 1'b0, 0, 1'b1);

        // Early frame end after 10 of 100 bytes
        fill_rand(10);
        run_capture("early_end", 32'h5000_0100, 100, 10, 1'b0, 0, 1'b0);
        w = (got_q.size() > 2) ? got_q[2] : '0;
        check("early_end_be", w.be, 4'b0011);

        // Unaligned base and address wrap
        fill_rand(16);
        run_capture("wrap", 32'hFFFF_FFFB, 16, 16, 1'b1, 3, 1'b0);

        // Randomized captures
        for (int k = 0; k < 6; k++) begin
            base = $urandom;
            sz   = $urandom_range(1, 40);
            np   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, sz) : sz;
            fill_rand(np);
            run_capture($sformatf("rand%0d", k), base, sz, np, 1'b1, 3, 1'b0);
        end

        // Zero size, then start held high must not retrigger
        got_q.delete();
        d0 = done_count;
        capture_imgsize = '0;
        buff = 32'h6000_0000;
        start_capture = 1'b1;
        tick();
        check("zero_cycle1_done", image_captured, 1'b0);
        tick();
        check("zero_cycle2_done", image_captured, 1'b1);
        check("zero_cycle2_standby", capture_standby, 1'b0);
        tick();
        check("zero_cycle3_done", image_captured, 1'b0);
        check("zero_cycle3_standby", capture_standby, 1'b1);
        capture_imgsize = 24'd8;
        repeat (10) tick();
        check("retrigger_done_pulses", done_count - d0, 1);
        check("zero_no_writes", got_q.size(), 0);
        check("retrigger_standby", capture_standby, 1'b1);
        start_capture = 1'b0;
        repeat (2) tick();

        // Reset mid-capture with words waiting in the FIFO
        d0 = done_count;
        wait_mode = 2;
        buff = 32'h7000_0000;
        capture_imgsize = 24'd100;
        start_capture = 1'b1;
        tick();
        tick();
        in_frame_valid = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            in_pix = 8'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("abort_write_pending", avm_bus.avm_write, 1'b1);
        check("abort_busy", capture_standby, 1'b0);
        reset_n = 1'b0;
        #1;
        check("abort_avm_write", avm_bus.avm_write, 1'b0);
        check("abort_standby", capture_standby, 1'b1);
        check("abort_address", avm_bus.avm_address, 32'd0);
        in_frame_valid = 1'b0;
        start_capture = 1'b0;
        wait_mode = 0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("abort_no_done", done_count - d0, 0);

        // Recovery after abort
        fill_seq(8'h11, 4);
        run_capture("after_reset", 32'h8000_0000, 4, 4, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
